// File: rtl/dwt_pkg.sv
// dwt_pkg: shared types and defaults for the lifting DWT sequencer.
package dwt_pkg;
    localparam int DW_DEF  = 8;
    localparam int AW_DEF  = 6;
    localparam int ROM_LAT = 1;
    typedef enum logic [2:0] {IDLE, RD_E0, RD_O, RD_E, CALC_H, CALC_L, EMIT, DONE} state_t;
    typedef enum logic {PREDICT, UPDATE} step_mode_t;
endpackage

// File: rtl/lifting_dwt_ctrl_if.sv
// lifting_dwt_ctrl_if: {L,H} coefficient stream with valid/ready handshake.
interface lifting_dwt_ctrl_if import dwt_pkg::*; #(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
);
    logic          coef_valid;
    logic          coef_ready;
    logic [DW-1:0] coef_l;
    logic [DW-1:0] coef_h;
    logic [AW-2:0] coef_idx;
    modport master(output coef_valid, coef_l, coef_h, coef_idx, input coef_ready);
    modport slave(input coef_valid, coef_l, coef_h, coef_idx, output coef_ready);
endinterface

// File: rtl/lifting_step.sv
// lifting_step: predict (a - (b+c)>>1) or update (a + (b+c)>>2), wrapping at DW bits.
module lifting_step import dwt_pkg::*; #(
    parameter int DW = DW_DEF
) (
    input  step_mode_t    mode,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    output logic [DW-1:0] y
);
    logic [DW:0]   sum;
    logic [DW-1:0] shr;
    always_comb begin
        sum = {1'b0, b} + {1'b0, c};
        shr = DW'(mode == PREDICT ? sum >> 1 : sum >> 2);
        y   = mode == PREDICT ? a - shr : a + shr;
    end
endmodule

// File: rtl/lifting_dwt_ctrl.sv
// lifting_dwt_ctrl: reads one row from a sync ROM, runs predict/update per even/odd pair
// and emits {L,H} pairs on a valid/ready stream.
module lifting_dwt_ctrl import dwt_pkg::*; #(
    parameter int N_SAMPLES = 64,
    parameter int DW        = DW_DEF,
    parameter int AW        = AW_DEF,
    parameter int BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [AW-1:0]      rom_addr,
    input  logic [DW-1:0]      rom_data,
    lifting_dwt_ctrl_if.master coef,
    output logic               busy,
    output logic               done
);
    localparam logic [AW-2:0] LAST_IDX = (AW-1)'(N_SAMPLES / 2 - 1);

    state_t        state, state_n;
    step_mode_t    mode;
    logic          ph, ph_n, cap, last, hs, rd_enter;
    logic [AW-2:0] idx, idx_n;
    logic [AW-1:0] addr_n;
    logic [DW-1:0] e_cur, e_nxt, o, h, l, h_prev;
    logic [DW-1:0] step_a, step_b, step_c, step_y;

    assign cap             = ph == 1'(ROM_LAT);
    assign last            = idx == LAST_IDX;
    assign hs              = state == EMIT && coef.coef_ready;
    assign busy            = state != IDLE && state != DONE;
    assign done            = state == DONE;
    assign coef.coef_valid = state == EMIT;
    assign coef.coef_l     = l;
    assign coef.coef_h     = h;
    assign coef.coef_idx   = idx;

    always_comb begin
        state_n = state;
        ph_n    = 1'b0;
        unique case (state)
            IDLE:    state_n = start ? RD_E0 : IDLE;
            RD_E0:   begin ph_n = !cap; state_n = cap ? RD_O : RD_E0; end
            RD_O:    begin ph_n = !cap; state_n = !cap ? RD_O : last ? CALC_H : RD_E; end
            RD_E:    begin ph_n = !cap; state_n = cap ? CALC_H : RD_E; end
            CALC_H:  state_n = CALC_L;
            CALC_L:  state_n = EMIT;
            EMIT:    state_n = !coef.coef_ready ? EMIT : last ? DONE : RD_O;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // The address is registered on entry to a read so the ROM sees it for the whole read.
    assign rd_enter = state_n inside {RD_E0, RD_O, RD_E} && !ph_n;
    assign idx_n    = state == IDLE ? '0 : (hs && !last) ? idx + (AW-1)'(1) : idx;
    assign addr_n   = state_n == RD_E0 ? AW'(BASE_ADDR) :
                      state_n == RD_O  ? AW'(BASE_ADDR) + {idx_n, 1'b1} :
                                         AW'(BASE_ADDR) + {idx, 1'b0} + AW'(2);

    assign mode   = state == CALC_L ? UPDATE : PREDICT;
    assign step_a = mode == UPDATE ? e_cur : o;
    assign step_b = mode == UPDATE ? (idx == '0 ? h : h_prev) : e_cur;
    assign step_c = mode == UPDATE ? h : e_nxt;

    lifting_step #(.DW(DW)) u_step (
        .mode (mode),
        .a    (step_a),
        .b    (step_b),
        .c    (step_c),
        .y    (step_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ph       <= 1'b0;
            idx      <= '0;
            rom_addr <= '0;
            e_cur    <= '0;
            e_nxt    <= '0;
            o        <= '0;
            h        <= '0;
            l        <= '0;
            h_prev   <= '0;
        end else begin
            state <= state_n;
            ph    <= ph_n;
            idx   <= idx_n;
            if (rd_enter) rom_addr <= addr_n;
            if (state == RD_E0 && cap) e_cur <= rom_data;
            if (state == RD_O && cap) o <= rom_data;
            if (state == RD_E && cap) e_nxt <= rom_data;
            else if (state == RD_O && cap && last) e_nxt <= e_cur;
            if (state == CALC_H) h <= step_y;
            if (state == CALC_L) l <= step_y;
            if (hs) begin
                h_prev <= h;
                e_cur  <= e_nxt;
            end
        end
    end
endmodule

// File: tb/tb_lifting_dwt_ctrl.sv
// tb_lifting_dwt_ctrl: three sequencer instances (N=4, N=64, N=62 at base 1) checked by
// per-instance scoreboards fed with hand-computed {idx,L,H,latency} entries.
module tb_lifting_dwt_ctrl;
    typedef struct {int idx; int l; int h; int dt;} exp_t;

    localparam int NS [3] = '{4, 64, 62};
    localparam int BA [3] = '{0, 0, 1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start [3];
    logic       ready [3];
    logic [5:0] rom_addr [3];
    logic       busy [3];
    logic       done [3];
    logic       valid [3];
    logic [7:0] cl [3];
    logic [7:0] ch [3];
    logic [4:0] cidx [3];
    logic [7:0] mem [3][64];
    logic       seen [3][64];
    exp_t       sb [3][$];
    int         hs_cnt [3];
    int         done_cnt [3];
    int         last_edge [3];
    int         addr_bad [3];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int g, input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL dut%0d %s: got %0d, expected %0d", g, name, got, want);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        lifting_dwt_ctrl_if #(.DW(8), .AW(6)) ifc ();
        logic [7:0] rd;
        logic       stalled = 1'b0;
        logic [7:0] snap_l, snap_h;
        logic [4:0] snap_idx;
        logic [5:0] snap_addr;
        exp_t       e;
        assign ifc.coef_ready = ready[g];
        assign valid[g] = ifc.coef_valid;
        assign cl[g]    = ifc.coef_l;
        assign ch[g]    = ifc.coef_h;
        assign cidx[g]  = ifc.coef_idx;
        lifting_dwt_ctrl #(.N_SAMPLES(NS[g]), .DW(8), .AW(6), .BASE_ADDR(BA[g])) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start[g]),
            .rom_addr (rom_addr[g]),
            .rom_data (rd),
            .coef     (ifc),
            .busy     (busy[g]),
            .done     (done[g])
        );
        always @(posedge clk) rd <= mem[g][rom_addr[g]];
        // Monitor: handshakes pop the scoreboard; stalls must hold outputs and rom_addr.
        always @(negedge clk) begin
            if (valid[g] && ready[g]) begin
                if (sb[g].size() == 0) chk(g, "extra_pair_idx", int'(cidx[g]), -1);
                else begin
                    e = sb[g].pop_front();
                    chk(g, "pair_idx", int'(cidx[g]), e.idx);
                    chk(g, "pair_L", int'(cl[g]), e.l);
                    chk(g, "pair_H", int'(ch[g]), e.h);
                    if (e.dt >= 0) chk(g, "pair_latency", cyc + 1 - last_edge[g], e.dt);
                end
                last_edge[g] = cyc + 1;
                hs_cnt[g]++;
            end
            if (valid[g] && !ready[g]) begin
                if (stalled) begin
                    chk(g, "stall_L", int'(cl[g]), int'(snap_l));
                    chk(g, "stall_H", int'(ch[g]), int'(snap_h));
                    chk(g, "stall_idx", int'(cidx[g]), int'(snap_idx));
                    chk(g, "stall_addr", int'(rom_addr[g]), int'(snap_addr));
                end
                stalled   = 1'b1;
                snap_l    = cl[g];
                snap_h    = ch[g];
                snap_idx  = cidx[g];
                snap_addr = rom_addr[g];
            end else stalled = 1'b0;
            if (done[g]) begin
                chk(g, "done_latency", cyc + 1 - last_edge[g], 1);
                done_cnt[g]++;
            end
            if (busy[g]) begin
                if (int'(rom_addr[g]) < BA[g] || int'(rom_addr[g]) > BA[g] + NS[g] - 1) addr_bad[g]++;
                seen[g][rom_addr[g]] = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int g);
        start[g] = 1'b1;
        tick();
        last_edge[g] = cyc;
        start[g] = 1'b0;
    endtask

    task automatic push_row(input int g, input int l, input int h, input int dt0);
        for (int i = 0; i < NS[g] / 2; i++)
            sb[g].push_back('{idx: i, l: l, h: h, dt: i == 0 ? dt0 : i == NS[g] / 2 - 1 ? 5 : 7});
    endtask

    task automatic wait_idle(input int g);
        int k = 0;
        while ((sb[g].size() != 0 || busy[g]) && k < 2000) begin
            tick();
            k++;
        end
        chk(g, "row_complete", int'(sb[g].size() == 0 && !busy[g]), 1);
        repeat (3) tick();
    endtask

    task automatic chk_zero(input int g);
        chk(g, "rst_rom_addr", int'(rom_addr[g]), 0);
        chk(g, "rst_valid", int'(valid[g]), 0);
        chk(g, "rst_L", int'(cl[g]), 0);
        chk(g, "rst_H", int'(ch[g]), 0);
        chk(g, "rst_idx", int'(cidx[g]), 0);
        chk(g, "rst_busy", int'(busy[g]), 0);
        chk(g, "rst_done", int'(done[g]), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n;
        for (int g = 0; g < 3; g++) begin
            start[g] = 1'b0;
            ready[g] = 1'b1;
            for (int a = 0; a < 64; a++) begin
                mem[g][a] = 8'd0;
                seen[g][a] = 1'b0;
            end
        end
        #2 rst_n = 1'b0;
        repeat (2) tick();
        for (int g = 0; g < 3; g++) chk_zero(g);
        rst_n = 1'b1;
        tick();

        // N=4 directed row: (252,215) at edge 9, (112,40) 5 later, done 1 after.
        mem[0][0] = 8'd145; mem[0][1] = 8'd56; mem[0][2] = 8'd49; mem[0][3] = 8'd89;
        sb[0].push_back('{idx: 0, l: 252, h: 215, dt: 9});
        sb[0].push_back('{idx: 1, l: 112, h: 40, dt: 5});
        do_start(0);
        wait_idle(0);
        chk(0, "hs_row1", hs_cnt[0], 2);
        chk(0, "done_row1", done_cnt[0], 1);

        // start pulses while busy and during DONE are dropped.
        sb[0].push_back('{idx: 0, l: 252, h: 215, dt: 9});
        sb[0].push_back('{idx: 1, l: 112, h: 40, dt: 5});
        do_start(0);
        repeat (3) tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        k = 0;
        while (!done[0] && k < 100) begin
            tick();
            k++;
        end
        chk(0, "done_seen", int'(done[0]), 1);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (30) tick();
        chk(0, "busy_after_dropped_start", int'(busy[0]), 0);
        chk(0, "hs_total", hs_cnt[0], 4);
        chk(0, "done_total", done_cnt[0], 2);
        chk(0, "queue_empty", sb[0].size(), 0);

        // Back-pressure on pair 0 of an all-255 row: H=0, L=255 throughout.
        for (int a = 0; a < 64; a++) mem[1][a] = 8'd255;
        ready[1] = 1'b0;
        push_row(1, 255, 0, -1);
        do_start(1);
        k = 0;
        while (!valid[1] && k < 50) begin
            tick();
            k++;
        end
        chk(1, "first_valid_seen", int'(valid[1]), 1);
        repeat (5) tick();
        ready[1] = 1'b1;
        wait_idle(1);
        chk(1, "hs_bp_row", hs_cnt[1], 32);
        chk(1, "done_bp_row", done_cnt[1], 1);

        // Reset during RD_O of pair 2, then a fresh row restarts at i=0.
        push_row(1, 255, 0, 9);
        do_start(1);
        k = 0;
        while (hs_cnt[1] != 34 && k < 200) begin
            tick();
            k++;
        end
        chk(1, "pre_reset_addr", int'(rom_addr[1]), 5);
        rst_n = 1'b0;
        #1;
        sb[1].delete();
        chk_zero(1);
        n = done_cnt[1];
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 64; a++) mem[1][a] = (a % 2 == 1) ? 8'd1 : 8'd0;
        push_row(1, 0, 1, 9);
        do_start(1);
        wait_idle(1);
        chk(1, "hs_after_reset", hs_cnt[1], 66);
        chk(1, "done_after_reset", done_cnt[1], n + 1);

        // Base 1, N=62: even samples 10, odd 20 -> H=10, L=15; guard words at 0 and 63.
        for (int a = 0; a < 64; a++) mem[2][a] = (a == 0 || a == 63) ? 8'd99 : ((a - 1) % 2 == 0 ? 8'd10 : 8'd20);
        push_row(2, 15, 10, 9);
        do_start(2);
        wait_idle(2);
        chk(2, "addr_out_of_range", addr_bad[2], 0);
        n = 0;
        for (int a = 1; a <= 62; a++) n += int'(seen[2][a]);
        chk(2, "addr_coverage", n, 62);
        chk(2, "done_c", done_cnt[2], 1);
        for (int g = 0; g < 2; g++) chk(g, "addr_out_of_range", addr_bad[g], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
